// File: rtl/uarc_recv_endpoint_if.sv
// UARC bus between a core0 sender and its receive endpoint.
// Requests and payloads flow master->slave; acks flow back.
interface uarc_recv_endpoint_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  enable;
  logic                  kill;
  logic                  kill_ack;
  logic                  incept;
  logic                  incept_ack;
  logic                  send;
  logic                  send_ack;
  logic                  stream;
  logic                  stream_ack;
  logic [WORD_WIDTH-1:0] data;
  logic [WORD_WIDTH-1:0] self_permission;
  logic [WORD_WIDTH-1:0] self_address;
  logic [WORD_WIDTH-1:0] incept_permission;
  logic [WORD_WIDTH-1:0] incept_address;

  modport master (
    output enable, kill, incept, send, stream,
    output data, self_permission, self_address,
    output incept_permission, incept_address,
    input  kill_ack, incept_ack, send_ack, stream_ack
  );

  modport slave (
    input  enable, kill, incept, send, stream,
    input  data, self_permission, self_address,
    input  incept_permission, incept_address,
    output kill_ack, incept_ack, send_ack, stream_ack
  );
endinterface

// File: rtl/uarc_recv_endpoint.sv
// UARC receive endpoint: acks bus requests, queues words, holds one incept.
// Optional UARC_RECV_PERM_CHECK_EN drops words failing the accept_mask test.
module uarc_recv_endpoint #(
  parameter int WORD_MAG        = 5,
  parameter int FIFO_ADDR_WIDTH = 3,
  localparam int WORD_WIDTH     = 1 << WORD_MAG
) (
  input  logic                     clk,
  input  logic                     reset,
  uarc_recv_endpoint_if.slave      bus,
  output logic                     out_valid,
  output logic [WORD_WIDTH-1:0]    out_data,
  input  logic                     pop,
  output logic [FIFO_ADDR_WIDTH:0] out_count,
  output logic                     incept_valid,
  output logic [WORD_WIDTH-1:0]    incept_perm_out,
  output logic [WORD_WIDTH-1:0]    incept_addr_out,
  input  logic                     incept_taken
`ifdef UARC_RECV_PERM_CHECK_EN
  ,
  input  logic [WORD_WIDTH-1:0]    accept_mask,
  output logic [WORD_WIDTH-1:0]    drop_count
`endif
);

  localparam int PW = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  full;
  logic                  empty;

  logic kill_ack_q;
  logic incept_ack_q;
  logic send_ack_q;

  logic kill_req;
  logic incept_req;
  logic send_req;
  logic stream_req;
  logic kill_acc;
  logic incept_acc;
  logic send_acc;
  logic stream_acc;
  logic stream_ok;
  logic word_acc;
  logic perm_ok;
  logic push;
  logic pop_en;
  logic unused_bits;

  assign out_count = wptr - rptr;
  assign full      = out_count == FULL_COUNT;
  assign empty     = wptr == rptr;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0
                   : mem[rptr[FIFO_ADDR_WIDTH-1:0]];

  // Raw presence of a higher class blocks lower ones,
  // even when that higher request cannot be acked yet.
  assign kill_req   = ~reset & bus.enable & bus.kill;
  assign incept_req = ~reset & bus.enable & bus.incept;
  assign send_req   = ~reset & bus.enable & bus.send;
  assign stream_req = ~reset & bus.enable & bus.stream;

  assign kill_acc   = kill_req & ~kill_ack_q;
  assign incept_acc = incept_req & ~kill_req
                    & ~incept_ack_q & ~incept_valid;
  assign send_acc   = send_req & ~kill_req & ~incept_req
                    & ~send_ack_q & ~full;
  assign stream_ok  = ~reset & bus.enable & ~full
                    & ~kill_req & ~incept_req & ~send_req;
  assign stream_acc = stream_req & stream_ok;
  assign word_acc   = send_acc | stream_acc;

  assign bus.kill_ack   = kill_ack_q;
  assign bus.incept_ack = incept_ack_q;
  assign bus.send_ack   = send_ack_q;
  assign bus.stream_ack = stream_ok;

`ifdef UARC_RECV_PERM_CHECK_EN
  assign perm_ok = |(bus.self_permission & accept_mask);
`else
  assign perm_ok = 1'b1;
`endif

  assign push   = word_acc & perm_ok;
  assign pop_en = pop & ~empty & ~kill_acc;

  assign unused_bits = ^{bus.self_address, bus.self_permission};

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_ack_q   <= 1'b0;
      incept_ack_q <= 1'b0;
      send_ack_q   <= 1'b0;
    end else begin
      kill_ack_q   <= kill_acc;
      incept_ack_q <= incept_acc;
      send_ack_q   <= send_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (kill_acc) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (pop_en)
        rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[FIFO_ADDR_WIDTH-1:0]] <= bus.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      incept_valid    <= 1'b0;
      incept_perm_out <= '0;
      incept_addr_out <= '0;
    end else if (kill_acc) begin
      incept_valid <= 1'b0;
    end else if (incept_acc) begin
      incept_valid    <= 1'b1;
      incept_perm_out <= bus.incept_permission;
      incept_addr_out <= bus.incept_address;
    end else if (incept_taken) begin
      incept_valid <= 1'b0;
    end
  end

`ifdef UARC_RECV_PERM_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= '0;
    else if (word_acc & ~perm_ok & ~&drop_count)
      drop_count <= drop_count + WORD_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_uarc_recv_endpoint.sv
// Directed bench for uarc_recv_endpoint.
// Define UARC_RECV_PERM_CHECK_EN to also cover the drop path.
module tb_uarc_recv_endpoint;
  localparam int WW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  logic out_valid;
  logic [WW-1:0] out_data;
  logic pop;
  logic [AW:0] out_count;
  logic incept_valid;
  logic [WW-1:0] incept_perm_out;
  logic [WW-1:0] incept_addr_out;
  logic incept_taken;
`ifdef UARC_RECV_PERM_CHECK_EN
  logic [WW-1:0] accept_mask;
  logic [WW-1:0] drop_count;
`endif

  int vectors = 0;
  int errors = 0;

  uarc_recv_endpoint_if #(.WORD_WIDTH(WW)) bus ();

  uarc_recv_endpoint #(
    .WORD_MAG(5),
    .FIFO_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .out_valid(out_valid),
    .out_data(out_data),
    .pop(pop),
    .out_count(out_count),
    .incept_valid(incept_valid),
    .incept_perm_out(incept_perm_out),
    .incept_addr_out(incept_addr_out),
    .incept_taken(incept_taken)
`ifdef UARC_RECV_PERM_CHECK_EN
    ,
    .accept_mask(accept_mask),
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pop = 1'b0;
    incept_taken = 1'b0;
    bus.enable = 1'b0;
    bus.kill = 1'b0;
    bus.incept = 1'b0;
    bus.send = 1'b0;
    bus.stream = 1'b0;
    bus.data = '0;
    bus.self_permission = 32'h1;
    bus.self_address = 32'h0;
    bus.incept_permission = '0;
    bus.incept_address = '0;
`ifdef UARC_RECV_PERM_CHECK_EN
    accept_mask = '1;
`endif
    tick();
    // Request on a reset edge is not accepted
    bus.enable = 1'b1;
    bus.send = 1'b1;
    bus.data = 32'h55;
    tick();
    chk("rst_count", out_count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_send_ack", bus.send_ack, 0);
    chk("rst_kill_ack", bus.kill_ack, 0);
    chk("rst_incept_valid", incept_valid, 0);
    chk("rst_incept_addr", incept_addr_out, 0);
    chk("rst_stream_ack", bus.stream_ack, 0);

    // Single send
    reset = 1'b0;
    bus.data = 32'hDEADBEEF;
    tick();
    chk("send_ack", bus.send_ack, 1);
    chk("send_valid", out_valid, 1);
    chk("send_data", out_data, 32'hDEADBEEF);
    chk("send_count", out_count, 1);
    bus.send = 1'b0;
    tick();
    chk("send_ack_pulse", bus.send_ack, 0);
    chk("send_count2", out_count, 1);
    pop = 1'b1;
    tick();
    chk("pop_count", out_count, 0);
    chk("pop_valid", out_valid, 0);
    tick();
    chk("pop_empty_count", out_count, 0);
    pop = 1'b0;

    // Stream until full
    bus.stream = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.data = i;
      #1;
      chk($sformatf("stream_ack_%0d", i), bus.stream_ack, (i <= 8));
      tick();
    end
    chk("full_count", out_count, 8);
    chk("full_head", out_data, 1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    #1;
    chk("after_pop_count", out_count, 7);
    chk("after_pop_head", out_data, 2);
    chk("after_pop_sack", bus.stream_ack, 1);
    tick();
    bus.stream = 1'b0;
    chk("word9_count", out_count, 8);
    chk("word9_head", out_data, 2);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("drain_%0d", k), out_data, k);
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    chk("drained_count", out_count, 0);

    // Five words plus held incept, then kill
    bus.stream = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data = 32'h100 + i;
      tick();
    end
    bus.stream = 1'b0;
    chk("five_count", out_count, 5);
    bus.incept = 1'b1;
    bus.incept_permission = 32'hA5;
    bus.incept_address = 32'h1234;
    tick();
    bus.incept = 1'b0;
    chk("inc_ack", bus.incept_ack, 1);
    chk("inc_valid", incept_valid, 1);
    chk("inc_perm", incept_perm_out, 32'hA5);
    chk("inc_addr", incept_addr_out, 32'h1234);
    bus.kill = 1'b1;
    pop = 1'b1;
    tick();
    bus.kill = 1'b0;
    pop = 1'b0;
    chk("kill_ack", bus.kill_ack, 1);
    chk("kill_count", out_count, 0);
    chk("kill_valid", out_valid, 0);
    chk("kill_incept", incept_valid, 0);
    tick();
    chk("kill_ack_pulse", bus.kill_ack, 0);

    // Incept and send on the same edge
    bus.incept = 1'b1;
    bus.send = 1'b1;
    bus.incept_address = 32'hCAFE;
    bus.data = 32'h77;
    tick();
    chk("is_inc_ack", bus.incept_ack, 1);
    chk("is_send_ack0", bus.send_ack, 0);
    chk("is_inc_addr", incept_addr_out, 32'hCAFE);
    tick();
    bus.incept = 1'b0;
    chk("is_inc_ack_pulse", bus.incept_ack, 0);
    chk("is_send_ack1", bus.send_ack, 0);
    tick();
    bus.send = 1'b0;
    chk("is_send_ack2", bus.send_ack, 1);
    chk("is_count", out_count, 1);
    incept_taken = 1'b1;
    pop = 1'b1;
    tick();
    incept_taken = 1'b0;
    pop = 1'b0;
    chk("taken_valid", incept_valid, 0);
    chk("taken_count", out_count, 0);

    // Disabled bus
    bus.enable = 1'b0;
    bus.send = 1'b1;
    bus.stream = 1'b1;
    bus.data = 32'h99;
    #1;
    chk("dis_stream_ack", bus.stream_ack, 0);
    bus.stream = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("dis_ack_%0d", i), bus.send_ack, 0);
    end
    chk("dis_count", out_count, 0);
    bus.enable = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("en_ack", bus.send_ack, 1);
    chk("en_data", out_data, 32'h99);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("en_pop", out_count, 0);

`ifdef UARC_RECV_PERM_CHECK_EN
    accept_mask = 32'h1;
    bus.self_permission = 32'h2;
    bus.send = 1'b1;
    bus.data = 32'h11;
    tick();
    bus.send = 1'b0;
    chk("pc_ack1", bus.send_ack, 1);
    chk("pc_count1", out_count, 0);
    chk("pc_drop1", drop_count, 1);
    tick();
    bus.self_permission = 32'h1;
    bus.send = 1'b1;
    bus.data = 32'h22;
    tick();
    bus.send = 1'b0;
    chk("pc_ack2", bus.send_ack, 1);
    chk("pc_count2", out_count, 1);
    chk("pc_data2", out_data, 32'h22);
    chk("pc_drop2", drop_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
